// File: rtl/vga_sync_gen_if.sv
// Video timing bundle produced by vga_sync_gen: pixel strobe, raster
// position, blanking and sync levels, and the once-per-frame update strobe.
interface vga_sync_gen_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  // Timing generator drives the bundle.
  modport master (
    output p_tick, x, y, video_on, hsync, vsync, frame_tick
  );

  // Pixel pipeline / game logic consumes it.
  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, frame_tick
  );
endinterface : vga_sync_gen_if

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator. A clock divider produces the pixel strobe,
// x/y counters walk the full raster, and every decoded output is registered
// from the next-state counter values so it lines up with x/y exactly.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int VS_START = V_DISPLAY + V_FRONT;

  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS   = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO   = 10'(HS_START);
  localparam logic [9:0] HS_HI   = 10'(HS_START + H_SYNC - 1);
  localparam logic [9:0] VS_LO   = 10'(VS_START);
  localparam logic [9:0] VS_HI   = 10'(VS_START + V_SYNC - 1);
  localparam logic       SYNC_ON = (SYNC_POL != 0);

  // Reject parameter sets the 4-bit divider or 10-bit counters cannot hold.
  if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be in 2..16");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must fit in 10 bits");
  end
  if (H_DISPLAY < 1 || V_DISPLAY < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_bad_geom
    $error("vga_sync_gen: display and sync widths must be non-zero");
  end

  // Registered state.
  logic [3:0] div_q;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic       p_tick_q;
  logic       video_on_q;
  logic       hsync_q;
  logic       vsync_q;
  logic       frame_tick_q;

  // Next-state values.
  logic       advance;
  logic [3:0] div_next;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       p_tick_next;
  logic       video_on_next;
  logic       hsync_next;
  logic       vsync_next;
  logic       frame_tick_next;

  // Next-state counters and the output decode taken from them.
  always_comb begin
    // NOTE: every signal gets a default at the top so no path through the
    // block leaves it unassigned; a missing default here infers a latch.
    advance  = (div_q == DIV_MAX);
    div_next = div_q + 4'd1;
    x_next   = x_q;
    y_next   = y_q;

    if (advance) begin
      div_next = '0;
      if (x_q == H_LAST) begin
        x_next = '0;
        y_next = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_next = x_q + 10'd1;
      end
    end

    p_tick_next     = (div_next == DIV_MAX);
    video_on_next   = (x_next < H_VIS) && (y_next < V_VIS);
    hsync_next      = ((x_next >= HS_LO) && (x_next <= HS_HI)) ? SYNC_ON : ~SYNC_ON;
    vsync_next      = ((y_next >= VS_LO) && (y_next <= VS_HI)) ? SYNC_ON : ~SYNC_ON;
    // Only the edge that moves the raster onto (0, V_DISPLAY) raises it, so
    // the strobe lasts one clk even though x/y then hold for CLK_DIV clks.
    frame_tick_next = advance && (x_next == '0) && (y_next == V_VIS);
  end

  // State and output registers; reset parks the raster at the top-left pixel.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all state uses non-blocking assignment so every register samples
    // the pre-edge values; blocking here would create ordering races.
    if (reset) begin
      div_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      p_tick_q     <= 1'b0;
      video_on_q   <= 1'b1;
      hsync_q      <= ~SYNC_ON;
      vsync_q      <= ~SYNC_ON;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_next;
      x_q          <= x_next;
      y_q          <= y_next;
      p_tick_q     <= p_tick_next;
      video_on_q   <= video_on_next;
      hsync_q      <= hsync_next;
      vsync_q      <= vsync_next;
      frame_tick_q <= frame_tick_next;
    end
  end

  // Outputs come straight from flops: no input reaches them combinationally.
  assign vga.p_tick     = p_tick_q;
  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.video_on   = video_on_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.frame_tick = frame_tick_q;

endmodule : vga_sync_gen
